// File: rtl/da_frame_buf.sv
// Sample-frame staging buffer for the SPI DAC serializer: fills a shadow bank
// over valid/ready and swaps it into the active bank atomically on frame_take.
module da_frame_buf #(
  parameter int NCH = 8,
  parameter int DW  = 16,
  parameter int CHW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CHW-1:0]    s_ch,
  input  logic [DW-1:0]     s_data,
  input  logic              frame_take,
  output logic [NCH*DW-1:0] frame_data,
  output logic              frame_new,
  output logic              frame_stale,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  state_t              state_q, state_d;
  logic [NCH*DW-1:0]   shadow_q, shadow_d;
  logic [NCH*DW-1:0]   active_q, active_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic                frame_new_q, frame_new_d;
  logic                frame_stale_q, frame_stale_d;
  logic [15:0]         underrun_q, underrun_d;

  logic                accept;
  logic [NCH-1:0]      wr_sel;
  logic [NCH*DW-1:0]   wr_bits;

  assign s_ready = (state_q == FILL);
  assign accept  = s_valid && s_ready;

  // One-hot channel select; an index >= NCH shifts out to zero and is discarded.
  assign wr_sel = accept ? (NCH'(1) << s_ch) : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_wr_bits
    assign wr_bits[g*DW +: DW] = {DW{wr_sel[g]}};
  end

  always_comb begin
    state_d       = state_q;
    shadow_d      = (shadow_q & ~wr_bits) | ({NCH{s_data}} & wr_bits);
    active_d      = active_q;
    mask_d        = mask_q | wr_sel;
    frame_new_d   = 1'b0;
    frame_stale_d = 1'b0;
    underrun_d    = underrun_q;

    if (state_q == FILL && (&mask_d)) begin
      state_d = FULL;
    end

    // Writes only happen in FILL, so a FULL take never races a write.
    if (frame_take) begin
      if (state_q == FULL) begin
        active_d    = shadow_q;
        mask_d      = '0;
        state_d     = FILL;
        frame_new_d = 1'b1;
      end else begin
        frame_stale_d = 1'b1;
        if (underrun_q != '1) begin
          underrun_d = underrun_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      shadow_q      <= '0;
      active_q      <= '0;
      mask_q        <= '0;
      frame_new_q   <= 1'b0;
      frame_stale_q <= 1'b0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      mask_q        <= mask_d;
      frame_new_q   <= frame_new_d;
      frame_stale_q <= frame_stale_d;
      underrun_q    <= underrun_d;
    end
  end

  assign frame_data   = active_q;
  assign frame_new    = frame_new_q;
  assign frame_stale  = frame_stale_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_da_frame_buf.sv
// Randomized self-checking bench for da_frame_buf against an array-based frame model.
module tb_da_frame_buf;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int CHW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [CHW-1:0]    s_ch = '0;
  logic [DW-1:0]     s_data = '0;
  logic              frame_take = 1'b0;
  logic [NCH*DW-1:0] frame_data;
  logic              frame_new;
  logic              frame_stale;
  logic [15:0]       underrun_cnt;

  da_frame_buf #(.NCH(NCH), .DW(DW), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
    .s_data(s_data), .frame_take(frame_take), .frame_data(frame_data),
    .frame_new(frame_new), .frame_stale(frame_stale), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays of channel codes plus a count of filled channels.
  logic [DW-1:0] m_shadow [NCH];
  logic [DW-1:0] m_active [NCH];
  bit            m_filled [NCH];
  bit            m_full;
  bit            m_new, m_stale;
  int            m_cnt;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = '0; m_active[k] = '0; m_filled[k] = 0;
    end
    m_full = 0; m_new = 0; m_stale = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input int ch, input logic [DW-1:0] d, input bit tk);
    bit was_full;
    int nfilled;
    was_full = m_full;
    m_new = 0; m_stale = 0;
    if (!was_full && v && ch < NCH) begin
      m_shadow[ch] = d;
      m_filled[ch] = 1;
      nfilled = 0;
      for (int k = 0; k < NCH; k++) nfilled += int'(m_filled[k]);
      if (nfilled == NCH) m_full = 1;
    end
    if (tk) begin
      if (was_full) begin
        for (int k = 0; k < NCH; k++) begin
          m_active[k] = m_shadow[k]; m_filled[k] = 0;
        end
        m_full = 0; m_new = 1;
      end else begin
        m_stale = 1;
        if (m_cnt < 16'hFFFF) m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NCH; k++)
      check_eq($sformatf("frame_data[%0d]", k), 128'(frame_data[k*DW +: DW]), 128'(m_active[k]));
    check_eq("frame_new", 128'(frame_new), 128'(m_new));
    check_eq("frame_stale", 128'(frame_stale), 128'(m_stale));
    check_eq("underrun_cnt", 128'(underrun_cnt), 128'(m_cnt));
    check_eq("s_ready_post", 128'(s_ready), 128'(!m_full));
  endtask

  task automatic step(input bit v, input int ch, input logic [DW-1:0] d, input bit tk);
    @(negedge clk);
    s_valid = v; s_ch = CHW'(ch); s_data = d; frame_take = tk;
    #1 check_eq("s_ready_pre", 128'(s_ready), 128'(!m_full));
    @(posedge clk);
    model_edge(v, ch, d, tk);
    #1 check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; frame_take = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 check_outputs();
    #13 rst = 1'b0;

    // In-order frame, then a take delivers it.
    for (int k = 0; k < NCH; k++) step(1, k, 16'h1000 + 16'(k), 0);
    check_eq("ready_low_after_ch7", 128'(s_ready), 128'(0));
    step(0, 0, 16'h0, 1);
    check_eq("frame_1000", 128'(frame_data), 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    check_eq("new_after_take", 128'(frame_new), 128'(1));
    step(0, 0, 16'h0, 0);

    // Stale takes from reset.
    do_reset();
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    check_eq("underrun_two", 128'(underrun_cnt), 128'(2));

    // Duplicate write does not complete the mask early.
    step(1, 3, 16'hAAAA, 0);
    step(1, 3, 16'h5555, 0);
    for (int k = 0; k < NCH; k++) if (k != 3 && k != 7) step(1, k, 16'h2000 + 16'(k), 0);
    check_eq("no_early_full", 128'(s_ready), 128'(1));
    step(1, 7, 16'h2007, 0);
    step(0, 0, 16'h0, 1);
    check_eq("ch3_dup", 128'(frame_data[3*DW +: DW]), 128'(16'h5555));

    // Mask completes on the same edge as a take: stale now, delivered next take.
    for (int k = 0; k < NCH - 1; k++) step(1, k, 16'h3000 + 16'(k), 0);
    step(1, 7, 16'h3007, 1);
    check_eq("coincide_stale", 128'(frame_stale), 128'(1));
    check_eq("coincide_full", 128'(s_ready), 128'(0));
    step(0, 0, 16'h0, 1);
    check_eq("coincide_new", 128'(frame_new), 128'(1));
    check_eq("coincide_ch7", 128'(frame_data[7*DW +: DW]), 128'(16'h3007));

    // Reset mid-stream discards everything.
    for (int k = 0; k < 4; k++) step(1, k, 16'h4000 + 16'(k), 0);
    do_reset();
    check_eq("rst_frame_zero", 128'(frame_data), 128'(0));
    step(0, 0, 16'h0, 1);
    check_eq("post_rst_stale", 128'(frame_stale), 128'(1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, NCH - 1)), 16'($urandom),
           $urandom_range(0, 9) < 2);

    // Saturation of the underrun counter.
    do_reset();
    for (int i = 0; i < 65534; i++) step(0, 0, 16'h0, 1);
    check_eq("underrun_fffe", 128'(underrun_cnt), 128'(16'hFFFE));
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1);
    check_eq("underrun_sat", 128'(underrun_cnt), 128'(16'hFFFF));
    step(0, 0, 16'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/da_frame_buf.md
Name: da_frame_buf

Overview:
- Sample-frame staging buffer directly upstream of the SPI DAC serializer.
- Collects per-channel 16-bit DAC codes from a sample source over a valid/ready stream into a shadow bank.
- When a full 8-channel frame is assembled and the serializer requests a frame at the start of a data burst, it atomically swaps the shadow bank into the active bank.
- The serializer's per-channel data words are therefore never torn mid-burst.

Parameters:
NCH, 8, number of DAC channels per frame
DW, 16, bits per channel code
CHW, 3, width of channel index (ceil log2 NCH)

Ports:
clk  in  1  system clock (100 MHz domain of the serializer)
rst  in  1  asynchronous, active-high reset
s_valid  in  1  upstream sample valid
s_ready  out  1  buffer can accept a sample
s_ch  in  CHW  target channel of sample
s_data  in  DW  channel code
frame_take  in  1  1-cycle pulse from serializer at each IDLE->address-phase transition
frame_data  out  NCH*DW  active bank; channel k at [k*DW +: DW]
frame_new  out  1  1-cycle pulse: last take delivered a fresh frame
frame_stale  out  1  1-cycle pulse: last take found no complete frame; old frame repeated
underrun_cnt  out  16  count of stale takes, saturating

Behaviour:
- Reset (async, rst=1): active bank = 0, shadow bank = 0, fill_mask = 0, state = FILL, frame_new = 0, frame_stale = 0, underrun_cnt = 0. s_ready reads 1 once state = FILL.
- States: FILL (accepting samples) and FULL (shadow complete, waiting for take).
- s_ready = (state == FILL); combinational from registered state only, with no dependency on s_valid.
- Handshake: a sample is accepted on a rising edge with s_valid & s_ready.
  - On accept: shadow[s_ch] <= s_data and fill_mask[s_ch] <= 1.
  - s_ch >= NCH (only reachable when NCH < 2^CHW): accepted and discarded; mask unchanged.
  - Duplicate write to an already-filled channel: overwrites the data; mask unchanged.
- FILL -> FULL: on the edge where the accepted write makes fill_mask all-ones. From the next cycle s_ready = 0.
- frame_take is evaluated against the registered state at that edge:
  - state FULL: active <= shadow, fill_mask <= 0, state <= FILL. frame_new = 1 in the following cycle.
  - state FILL: active unchanged, underrun_cnt <= underrun_cnt + 1, holding at 16'hFFFF. frame_stale = 1 in the following cycle. Any accepted write in the same cycle is still applied; if that write completes the mask, state <= FULL. The frame is delivered on the next take, not this one.
- No sample is accepted in FULL, so take-in-FULL and write never coincide.
- Latency: frame_data reflects the new frame on the edge that samples frame_take. The serializer samples channel words no earlier than 8 address bits later, so it sees a stable bank for the whole 8x16-bit burst.
- frame_take asserted on consecutive cycles: each pulse is evaluated independently. The second pulse after a swap sees FILL and counts as stale.
- frame_new and frame_stale are mutually exclusive and registered; they are 0 on every cycle without a take.
- Reset mid-frame: partial shadow contents and the mask are discarded. The active bank returns to 0, so the DAC is driven with code 0 on the next burst.

Test Plan:
- Reset, then write ch0..7 = 16'h1000+k in order, then pulse take -> s_ready falls the cycle after the ch7 write; frame_data = {16'h1007,...,16'h1000}; frame_new = 1 for one cycle; s_ready back to 1.
- Pulse take with no writes after reset -> frame_data = 0, frame_stale = 1, underrun_cnt = 1. A second take -> underrun_cnt = 2.
- Write ch3 = 16'hAAAA then ch3 = 16'h5555, fill the rest, take -> channel 3 = 16'h5555; no early transition to FULL after the duplicate.
- Complete the mask on the same edge as a take (ch7 write plus take) -> frame_stale, active unchanged, state FULL. The next take swaps in the frame with frame_new.
- Force underrun_cnt to 16'hFFFE, issue 3 stale takes -> saturates at 16'hFFFF.
- Load a frame, write ch0..3 of the next, assert rst for 1 cycle mid-stream -> frame_data = 0, s_ready = 1. A take immediately after reset is stale.
